// File: rtl/jtkcpu_stkseq_pkg.sv
// Shared constants for the stack push/pull sequencer.
package jtkcpu_stkseq_pkg;

  // Sequence mode codes presented on the mode input
  localparam logic [1:0] STK_PSH = 2'd0;
  localparam logic [1:0] STK_PUL = 2'd1;
  localparam logic [1:0] STK_INT = 2'd2;
  localparam logic [1:0] STK_RTI = 2'd3;

  // Default register layout: upper four registers are 16-bit, lower four are 8-bit
  localparam int unsigned DEF_NREG = 8;
  localparam logic [7:0]  DEF_WIDE = 8'hF0;

  // PC sits in the top mask bit, CC in the bottom one
  localparam int unsigned PC_BIT = DEF_NREG - 1;
  localparam int unsigned CC_BIT = 0;

  typedef enum logic [1:0] {StIdle, StXfer, StFin} stk_state_e;

endpackage

// File: rtl/jtkcpu_stkseq_if.sv
// Control/memory handshake between microcode sequencer, datapath and stack sequencer.
interface jtkcpu_stkseq_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned SW   = $clog2(NREG)
);
  logic            cen;
  logic            start;
  logic [1:0]      mode;
  logic [NREG-1:0] mask;
  logic            full_int;
  logic [7:0]      rd_data;
  logic            mem_ack;
  logic            busy;
  logic            mem_req;
  logic            mem_wr;
  logic [SW-1:0]   reg_sel;
  logic            hi_lon;
  logic            sp_dec;
  logic            sp_inc;
  logic            done;

  modport master (
    output cen, start, mode, mask, full_int, rd_data, mem_ack,
    input  busy, mem_req, mem_wr, reg_sel, hi_lon, sp_dec, sp_inc, done
  );

  modport slave (
    input  cen, start, mode, mask, full_int, rd_data, mem_ack,
    output busy, mem_req, mem_wr, reg_sel, hi_lon, sp_dec, sp_inc, done
  );
endinterface

// File: rtl/jtkcpu_stkseq_pri.sv
// Priority encoder: index of the highest (hi_first=1) or lowest set bit of vec.
module jtkcpu_stkseq_pri #(
  parameter int unsigned NREG = 8,
  parameter int unsigned SW   = $clog2(NREG)
) (
  input  logic [NREG-1:0] vec,
  input  logic            hi_first,
  output logic [SW-1:0]   idx
);

  // Last match wins, so the scan order picks the end of the vector that has priority
  always_comb begin
    idx = '0;
    if (hi_first) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (vec[i]) idx = SW'(i);
      end
    end else begin
      for (int i = int'(NREG) - 1; i >= 0; i--) begin
        if (vec[i]) idx = SW'(i);
      end
    end
  end

endmodule

// File: rtl/jtkcpu_stkseq.sv
// Stack push/pull sequencer: walks a register mask, one byte access per step.
module jtkcpu_stkseq
  import jtkcpu_stkseq_pkg::*;
#(
  parameter int unsigned     NREG = 8,
  parameter logic [NREG-1:0] WIDE = DEF_WIDE,
  parameter int unsigned     SW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  jtkcpu_stkseq_if.slave      bus
);

  localparam logic [NREG-1:0] PcMask = {1'b1, {(NREG-1){1'b0}}};
  localparam logic [NREG-1:0] CcMask = NREG'(1);

  stk_state_e      state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic            push_q, push_d;
  logic            rti_q, rti_d;
  logic            second_q, second_d;   // first byte of a 16-bit register already moved

  logic [NREG-1:0] work_mask;
  logic [SW-1:0]   sel;
  logic            cur_wide;

  logic            busy, mem_req, mem_wr, hi_lon, sp_dec, sp_inc, done;
  logic [SW-1:0]   reg_sel;

  jtkcpu_stkseq_pri #(
    .NREG (NREG),
    .SW   (SW)
  ) u_pri (
    .vec      (mask_q),
    .hi_first (push_q),
    .idx      (sel)
  );

  assign cur_wide = WIDE[sel];

  // Working mask chosen from the request mode
  always_comb begin
    work_mask = bus.mask;
    unique case (bus.mode)
      STK_INT: work_mask = bus.full_int ? '1 : (PcMask | CcMask);
      STK_RTI: work_mask = CcMask;
      default: work_mask = bus.mask;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    push_d   = push_q;
    rti_d    = rti_q;
    second_d = second_q;
    busy     = 1'b0;
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    reg_sel  = '0;
    hi_lon   = 1'b0;
    sp_dec   = 1'b0;
    sp_inc   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && bus.cen) begin
          mask_d   = work_mask;
          push_d   = (bus.mode == STK_PSH) || (bus.mode == STK_INT);
          rti_d    = (bus.mode == STK_RTI);
          second_d = 1'b0;
          state_d  = (work_mask == '0) ? StFin : StXfer;
        end
      end
      StXfer: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_wr  = push_q;
        reg_sel = sel;
        // Push stores low then high; pull loads high then low
        hi_lon  = cur_wide && (push_q ? second_q : !second_q);
        if (bus.mem_ack && bus.cen) begin
          sp_dec = push_q;
          sp_inc = !push_q;
          if (cur_wide && !second_q) begin
            second_d = 1'b1;
          end else begin
            second_d    = 1'b0;
            mask_d[sel] = 1'b0;
            // RTI: pulled CC's E flag decides between full and PC-only unstack
            if (rti_q && (sel == SW'(CC_BIT))) begin
              mask_d = bus.rd_data[7] ? ~CcMask : PcMask;
            end
          end
          if (mask_d == '0) state_d = StFin;
        end
      end
      StFin: begin
        if (bus.cen) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; everything holds while cen is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      push_q   <= 1'b0;
      rti_q    <= 1'b0;
      second_q <= 1'b0;
    end else if (bus.cen) begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      push_q   <= push_d;
      rti_q    <= rti_d;
      second_q <= second_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.mem_req = mem_req;
  assign bus.mem_wr  = mem_wr;
  assign bus.reg_sel = reg_sel;
  assign bus.hi_lon  = hi_lon;
  assign bus.sp_dec  = sp_dec;
  assign bus.sp_inc  = sp_inc;
  assign bus.done    = done;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Self-checking bench for jtkcpu_stkseq against a byte-list reference model.
module tb_jtkcpu_stkseq;

  localparam int unsigned NREG = 8;
  localparam logic [7:0]  WIDE = 8'hF0;

  logic clk;
  logic rst;

  jtkcpu_stkseq_if #(.NREG(NREG)) bus ();

  jtkcpu_stkseq #(.NREG(NREG), .WIDE(WIDE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int exp_sel[$];
  int exp_hi[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append the byte transfers for one register mask in the given direction
  task automatic add_bytes(input logic [7:0] m, input bit push);
    if (push) begin
      for (int i = 7; i >= 0; i--) begin
        if (m[i]) begin
          exp_sel.push_back(i); exp_hi.push_back(0);
          if (WIDE[i]) begin exp_sel.push_back(i); exp_hi.push_back(1); end
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          if (WIDE[i]) begin exp_sel.push_back(i); exp_hi.push_back(1); end
          exp_sel.push_back(i); exp_hi.push_back(0);
        end
      end
    end
  endtask

  task automatic build(input logic [1:0] mode, input logic [7:0] m, input bit full, input bit e);
    exp_sel.delete();
    exp_hi.delete();
    case (mode)
      2'd0: add_bytes(m, 1);
      2'd1: add_bytes(m, 0);
      2'd2: add_bytes(full ? 8'hFF : 8'h81, 1);
      default: begin
        add_bytes(8'h01, 0);
        add_bytes(e ? 8'hFE : 8'h80, 0);
      end
    endcase
  endtask

  // waits >= 0: exact low-ack cycles before each ack; waits < 0: random 0..3
  task automatic run_seq(input string name, input logic [1:0] mode, input logic [7:0] m,
                         input bit full, input bit e, input int waits, input bit cen_rand);
    int  n, idx, cyc, wait_left, pulses, dones;
    bit  push, done_seen, cen_v, ack_v;
    build(mode, m, full, e);
    n    = exp_sel.size();
    push = (mode == 2'd0) || (mode == 2'd2);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = mode; bus.mask = m; bus.full_int = full;
    bus.cen = 1'b1; bus.mem_ack = $urandom_range(0, 1);
    bus.rd_data = {e, 7'($urandom)};
    #1;
    chk({name, ":idle_busy"}, 32'(bus.busy), 0);
    chk({name, ":idle_req"},  32'(bus.mem_req), 0);
    idx = 0; cyc = 0; pulses = 0; dones = 0; done_seen = 0;
    wait_left = (waits < 0) ? $urandom_range(0, 3) : waits;
    while (!done_seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      cen_v = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ack_v = (idx < n) ? (wait_left == 0) : 1'($urandom_range(0, 1));
      bus.cen = cen_v; bus.mem_ack = ack_v;
      bus.start = (idx < n) ? 1'($urandom_range(0, 1)) : 1'b0;   // ignored while busy
      bus.mode = 2'($urandom); bus.mask = 8'($urandom); bus.full_int = 1'($urandom);
      bus.rd_data = {e, 7'($urandom)};
      #1;
      if (idx < n) begin
        chk({name, ":busy"}, 32'(bus.busy), 1);
        chk({name, ":req"},  32'(bus.mem_req), 1);
        chk({name, ":wr"},   32'(bus.mem_wr), 32'(push));
        chk({name, ":sel"},  32'(bus.reg_sel), 32'(exp_sel[idx]));
        chk({name, ":hi"},   32'(bus.hi_lon), 32'(exp_hi[idx]));
        chk({name, ":dec"},  32'(bus.sp_dec), 32'(push && ack_v && cen_v));
        chk({name, ":inc"},  32'(bus.sp_inc), 32'(!push && ack_v && cen_v));
        chk({name, ":done_x"}, 32'(bus.done), 0);
        if (cen_v) begin
          if (ack_v) begin
            idx++;
            pulses++;
            wait_left = (waits < 0) ? $urandom_range(0, 3) : waits;
          end else if (wait_left > 0) begin
            wait_left--;
          end
        end
      end else begin
        chk({name, ":fin_req"},  32'(bus.mem_req), 0);
        chk({name, ":fin_busy"}, 32'(bus.busy), 0);
        chk({name, ":fin_done"}, 32'(bus.done), 32'(cen_v));
        if (cen_v) begin
          done_seen = 1;
          dones++;
        end
      end
    end
    chk({name, ":completed"}, 32'(done_seen), 1);
    chk({name, ":pulses"}, 32'(pulses), 32'(n));
    chk({name, ":done_cnt"}, 32'(dones), 1);
    // Cost check with immediate ack and no cen gaps: one cycle per byte plus FIN
    if (waits == 0 && !cen_rand) chk({name, ":cycles"}, 32'(cyc), 32'(n + 1));
    @(posedge clk); #1;
    bus.cen = 1'b1; bus.start = 1'b0; bus.mem_ack = 1'b0;
    #1;
    chk({name, ":back_idle"}, 32'(bus.busy), 0);
    chk({name, ":back_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cen = 1'b1; bus.start = 1'b0; bus.mode = 2'd0; bus.mask = 8'h00;
    bus.full_int = 1'b0; bus.rd_data = 8'h00; bus.mem_ack = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req",  32'(bus.mem_req), 0);
    chk("rst_wr",   32'(bus.mem_wr), 0);
    chk("rst_sel",  32'(bus.reg_sel), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_spd",  32'(bus.sp_dec | bus.sp_inc), 0);
    @(negedge clk);
    rst = 1'b0;

    run_seq("psh86",   2'd0, 8'h86, 0, 0, 0, 0);
    run_seq("pul31",   2'd1, 8'h31, 0, 0, 0, 0);
    run_seq("firq",    2'd2, 8'h00, 0, 0, 0, 0);
    run_seq("irq",     2'd2, 8'h00, 1, 0, 0, 0);
    run_seq("rti_e1",  2'd3, 8'h00, 0, 1, 0, 0);
    run_seq("rti_e0",  2'd3, 8'h00, 0, 0, 0, 0);
    run_seq("psh_w3",  2'd0, 8'h01, 0, 0, 3, 0);
    run_seq("psh_cen", 2'd0, 8'h86, 0, 0, 0, 1);
    run_seq("psh0",    2'd0, 8'h00, 0, 0, 0, 0);
    run_seq("pul0",    2'd1, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a push
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 2'd0; bus.mask = 8'hFF; bus.cen = 1'b1; bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy_pre", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_req",  32'(bus.mem_req), 0);
    chk("mid_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(bus.done), 0);
      chk("post_rst_busy", 32'(bus.busy), 0);
    end

    // Randomized sequences
    for (int t = 0; t < 25; t++) begin
      run_seq("rand", 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1,
              1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
